fpu_fsm: RTL and testbench

Instruction-sequencing controller for the half-precision FPU test core. After the UART/ICCM loader finishes programming the 1 KB instruction SRAM, it fetches words from SRAM read port 1 and presents each one to the main decoder. It holds each instruction until the execution side signals completion, then advances the PC. It sits between the instruction SRAM, the decoder (`Instruction_out`) and the stall checker (`Multi_Cycle`).

---
 rtl/fpu_fsm_pkg.sv | 13 +
 rtl/fpu_fsm.sv | 78 +++++++
 tb/tb_fpu_fsm.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/fpu_fsm_pkg.sv
// fpu_fsm_pkg: shared state encoding and program-address constants for the instruction sequencer
package fpu_fsm_pkg;
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_LOAD  = 3'd2,
      S_EXEC  = 3'd3,
      S_DONE  = 3'd4
   } state_e;
   localparam logic [31:0] END_OF_PROGRAM = 32'h0000_0000;
   localparam logic [31:0] PC_STEP        = 32'd4;
   localparam logic [31:0] PC_LAST        = 32'h0000_03FC;
endpackage

// File: rtl/fpu_fsm.sv
// fpu_fsm: fetches instructions from SRAM and holds each for the decoder until completion
module fpu_fsm
   import fpu_fsm_pkg::*;
(
   input  logic        clk,
   input  logic        rst_l,
   input  logic        Active_Process,
   input  logic        Activation_Signal,
   input  logic        Multi_Cycle,
   input  logic [31:0] Instruction,
   output logic        Memory_Activation,
   output logic [31:0] PC,
   output logic [31:0] Instruction_out
);
   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        pending_q, pending_d;
   logic        accept;

   assign Memory_Activation = (state_q == S_FETCH);
   assign PC                = pc_q;
   assign Instruction_out   = instr_q;
   assign accept            = (state_q == S_EXEC) && (Activation_Signal || pending_q) && !Multi_Cycle;

   // state, PC, held instruction and pending-completion registers
   always_ff @(posedge clk or posedge rst_l) begin
      if (rst_l) begin
         state_q   <= S_IDLE;
         pc_q      <= '0;
         instr_q   <= '0;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         pending_q <= pending_d;
      end
   end

   // next-state logic; a loader request overrides everything and restarts from address 0
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      pending_d = pending_q;
      case (state_q)
         S_IDLE: begin
            pc_d      = '0;
            instr_d   = '0;
            pending_d = 1'b0;
            state_d   = S_FETCH;
         end
         S_FETCH: state_d = S_LOAD;
         S_LOAD: begin
            instr_d = Instruction;
            state_d = (Instruction == END_OF_PROGRAM) ? S_DONE : S_EXEC;
         end
         S_EXEC: begin
            pending_d = pending_q || (Activation_Signal && Multi_Cycle);
            if (accept) begin
               instr_d   = '0;
               pending_d = 1'b0;
               pc_d      = (pc_q == PC_LAST) ? pc_q : pc_q + PC_STEP;
               state_d   = (pc_q == PC_LAST) ? S_DONE : S_FETCH;
            end
         end
         S_DONE:  state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
      if (Active_Process) begin
         state_d   = S_IDLE;
         pc_d      = '0;
         instr_d   = '0;
         pending_d = 1'b0;
      end
   end
endmodule

// File: tb/tb_fpu_fsm.sv
// tb_fpu_fsm: directed self-checking bench for the instruction sequencer with a simple SRAM model
module tb_fpu_fsm;
   logic        clk = 1'b0;
   logic        rst_l;
   logic        Active_Process;
   logic        Activation_Signal;
   logic        Multi_Cycle;
   logic [31:0] Instruction;
   logic        Memory_Activation;
   logic [31:0] PC;
   logic [31:0] Instruction_out;
   logic [31:0] mem [256];
   int          checks = 0;
   int          errors = 0;

   localparam logic [31:0] W0 = 32'h0050_0093;
   localparam logic [31:0] W1 = 32'h0010_8113;

   fpu_fsm dut (
      .clk(clk),
      .rst_l(rst_l),
      .Active_Process(Active_Process),
      .Activation_Signal(Activation_Signal),
      .Multi_Cycle(Multi_Cycle),
      .Instruction(Instruction),
      .Memory_Activation(Memory_Activation),
      .PC(PC),
      .Instruction_out(Instruction_out)
   );

   always #5 clk = ~clk;

   // SRAM read port 1: data registered one cycle after the enable
   always @(posedge clk) begin
      if (Memory_Activation) Instruction <= mem[PC[9:2]];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // return to IDLE, then release the loader; returns in the FETCH cycle
   task automatic restart();
      Active_Process = 1'b1;
      tick();
      Active_Process = 1'b0;
      tick();
   endtask

   initial begin
      rst_l = 1'b1;
      Active_Process = 1'b1;
      Activation_Signal = 1'b0;
      Multi_Cycle = 1'b0;
      Instruction = '0;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[0] = W0;
      mem[1] = W1;
      #12;
      check("reset_pc", PC, 32'h0);
      check("reset_instr", Instruction_out, 32'h0);
      check("reset_mem", {31'b0, Memory_Activation}, 32'h0);
      tick();
      rst_l = 1'b0;
      // idle hold
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_pc", PC, 32'h0);
         check("idle_instr", Instruction_out, 32'h0);
         check("idle_mem", {31'b0, Memory_Activation}, 32'h0);
      end
      // basic sequence
      Active_Process = 1'b0;
      tick();
      check("basic_fetch_mem", {31'b0, Memory_Activation}, 32'h1);
      check("basic_fetch_pc", PC, 32'h0);
      tick();
      check("basic_load_mem", {31'b0, Memory_Activation}, 32'h0);
      check("basic_load_instr", Instruction_out, 32'h0);
      tick();
      check("basic_exec0_instr", Instruction_out, W0);
      check("basic_exec0_pc", PC, 32'h0);
      Activation_Signal = 1'b1;
      tick();
      Activation_Signal = 1'b0;
      check("basic_pc4", PC, 32'h4);
      check("basic_clear0", Instruction_out, 32'h0);
      check("basic_fetch1_mem", {31'b0, Memory_Activation}, 32'h1);
      tick();
      tick();
      check("basic_exec1_instr", Instruction_out, W1);
      check("basic_exec1_pc", PC, 32'h4);
      Activation_Signal = 1'b1;
      tick();
      Activation_Signal = 1'b0;
      check("basic_pc8", PC, 32'h8);
      tick();
      tick();
      for (int i = 0; i < 3; i++) begin
         check("basic_done_pc", PC, 32'h8);
         check("basic_done_instr", Instruction_out, 32'h0);
         check("basic_done_mem", {31'b0, Memory_Activation}, 32'h0);
         tick();
      end
      // stall with completion during stall cycle 2
      restart();
      tick();
      tick();
      check("stall_exec_instr", Instruction_out, W0);
      Multi_Cycle = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i == 1) Activation_Signal = 1'b1;
         tick();
         Activation_Signal = 1'b0;
         check("stall_hold_instr", Instruction_out, W0);
         check("stall_hold_pc", PC, 32'h0);
      end
      Multi_Cycle = 1'b0;
      tick();
      check("stall_adv_pc", PC, 32'h4);
      check("stall_adv_mem", {31'b0, Memory_Activation}, 32'h1);
      // delayed completion
      restart();
      tick();
      tick();
      for (int i = 0; i < 20; i++) begin
         check("delay_hold_instr", Instruction_out, W0);
         check("delay_hold_pc", PC, 32'h0);
         tick();
      end
      Activation_Signal = 1'b1;
      tick();
      Activation_Signal = 1'b0;
      check("delay_adv_pc", PC, 32'h4);
      check("delay_adv_instr", Instruction_out, 32'h0);
      // last address: every word nonzero
      Active_Process = 1'b1;
      tick();
      for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
      restart();
      for (int i = 0; i < 256; i++) begin
         tick();
         tick();
         check("last_instr", Instruction_out, 32'hA000_0000 | i);
         check("last_pc", PC, i * 4);
         Activation_Signal = 1'b1;
         tick();
         Activation_Signal = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
         check("last_done_pc", PC, 32'h3FC);
         check("last_done_instr", Instruction_out, 32'h0);
         check("last_done_mem", {31'b0, Memory_Activation}, 32'h0);
         tick();
      end
      // asynchronous reset mid-EXEC at PC 4
      restart();
      tick();
      tick();
      Activation_Signal = 1'b1;
      tick();
      Activation_Signal = 1'b0;
      tick();
      tick();
      check("rst_pre_pc", PC, 32'h4);
      #2 rst_l = 1'b1;
      #1;
      check("rst_async_pc", PC, 32'h0);
      check("rst_async_instr", Instruction_out, 32'h0);
      check("rst_async_mem", {31'b0, Memory_Activation}, 32'h0);
      Active_Process = 1'b1;
      tick();
      rst_l = 1'b0;
      // reload at PC 8 coinciding with a completion; stray completion in FETCH ignored afterwards
      restart();
      for (int i = 0; i < 2; i++) begin
         tick();
         tick();
         Activation_Signal = 1'b1;
         tick();
         Activation_Signal = 1'b0;
      end
      tick();
      tick();
      check("reload_pre_pc", PC, 32'h8);
      check("reload_pre_instr", Instruction_out, 32'hA000_0002);
      Active_Process = 1'b1;
      Activation_Signal = 1'b1;
      tick();
      Activation_Signal = 1'b0;
      check("reload_pc", PC, 32'h0);
      check("reload_instr", Instruction_out, 32'h0);
      Active_Process = 1'b0;
      tick();
      check("reload_fetch_mem", {31'b0, Memory_Activation}, 32'h1);
      Activation_Signal = 1'b1;
      tick();
      Activation_Signal = 1'b0;
      tick();
      check("reload_exec_instr", Instruction_out, 32'hA000_0000);
      tick();
      check("ignore_pc", PC, 32'h0);
      check("ignore_instr", Instruction_out, 32'hA000_0000);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
